// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter slice: memory geometry,
// the arbiter FSM state encoding, requester port ids, and the address-error
// status code that the memory stage uses when it maps p0_err onto m_stat.
// Ports: none (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DEPTH        = 4096;
    localparam int ADDR_W       = 12;
    localparam int WORD_W       = 64;
    localparam int STARVE_LIMIT = 8;
    localparam int STARVE_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    localparam logic [3:0] STAT_ADR = 4'b0010;

    // A word address is legal only when it indexes an existing word; there is
    // no wrap, so every upper bit above the memory index must be zero.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                           input logic [WORD_W-1:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/dmem_prio_arb.sv
// -----------------------------------------------------------------------------
// dmem_prio_arb
// Combinational two-way priority picker. Port 0 (pipeline) normally wins;
// when the starvation guard fires and port 1 is requesting, port 1 wins.
// Nothing is granted outside the arbitration (idle) window.
// Ports:
//   p0_req, p1_req  requests from the two ports
//   starve_hit      port 1 has waited long enough to override priority
//   idle            arbitration window open (FSM idle, not in reset)
//   p0_gnt, p1_gnt  one-hot grants (both low when nothing is granted)
// -----------------------------------------------------------------------------
module dmem_prio_arb (
    input  logic p0_req,
    input  logic p1_req,
    input  logic starve_hit,
    input  logic idle,
    output logic p0_gnt,
    output logic p1_gnt
);
    import dmem_pkg::*;

    // Priority chain: starved port 1 first, then port 0, then port 1.
    // Being an if/else chain, at most one grant can ever be high.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (idle) begin
            if (starve_hit && p1_req) begin
                p1_gnt = 1'b1;
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port 4096 x 64 data memory between the pipeline memory
// stage (port 0, priority) and the loader/debug port (port 1). Each access is
// granted in IDLE, strobed to memory in the grant cycle when its address is
// legal, and answered in the following RESP cycle with read data or an
// address error.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   p{0,1}_req/we/addr/wdata      request side of each port
//   p{0,1}_gnt                    combinational accept (low = stall)
//   p{0,1}_rvalid/rdata/err       response, one cycle after the grant
//   mem_en/we/addr/wdata          strobe side of the synchronous-read memory
//   mem_rdata                     memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH        = dmem_pkg::DEPTH,
    parameter int ADDR_W       = dmem_pkg::ADDR_W,
    parameter int STARVE_LIMIT = dmem_pkg::STARVE_LIMIT,
    parameter int STARVE_W     = dmem_pkg::STARVE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [63:0]       p0_addr,
    input  logic [63:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [63:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [63:0]       p1_addr,
    input  logic [63:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [63:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);
    import dmem_pkg::*;

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                winner_q, winner_d;
    logic                we_q, we_d;
    logic                inrange_q, inrange_d;
    logic                rvalid_q, rvalid_d;

    logic                idle;
    logic                starve_hit;
    logic                any_gnt;
    logic                win_we;
    logic [63:0]         win_addr;
    logic [63:0]         win_wdata;
    logic                win_in_range;
    logic                resp_live;
    logic [63:0]         resp_data;

    // Arbitration is only open in IDLE, and never while reset is held, so a
    // reset cycle can never launch a memory access.
    assign idle       = (state_q == IDLE) && !reset;
    assign starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));

    dmem_prio_arb u_prio_arb (
        .p0_req     (p0_req),
        .p1_req     (p1_req),
        .starve_hit (starve_hit),
        .idle       (idle),
        .p0_gnt     (p0_gnt),
        .p1_gnt     (p1_gnt)
    );

    // Steer the winner's request onto the memory port in the grant cycle.
    // An illegal address still wins the slot but never strobes memory.
    always_comb begin
        any_gnt      = p0_gnt || p1_gnt;
        win_we       = p1_gnt ? p1_we    : p0_we;
        win_addr     = p1_gnt ? p1_addr  : p0_addr;
        win_wdata    = p1_gnt ? p1_wdata : p0_wdata;
        win_in_range = addr_in_range(win_addr, 64'(DEPTH));
        mem_en       = any_gnt && win_in_range;
        mem_we       = mem_en && win_we;
        mem_addr     = win_addr[ADDR_W-1:0];
        mem_wdata    = win_wdata;
    end

    // Next-state logic: IDLE moves to RESP on any grant and captures who won
    // and what kind of access it was; RESP always returns to IDLE. The
    // starvation counter only moves in IDLE, so it holds across RESP.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        winner_d  = winner_q;
        we_d      = we_q;
        inrange_d = inrange_q;
        rvalid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (p1_gnt || !p1_req) begin
                    starve_d = '0;
                end else if (!starve_hit) begin
                    starve_d = starve_q + 1'b1;
                end
                if (any_gnt) begin
                    state_d   = RESP;
                    winner_d  = p1_gnt ? PORT_LOAD : PORT_PIPE;
                    we_d      = win_we;
                    inrange_d = win_in_range;
                    rvalid_d  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured winner information, cleared synchronously on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            winner_q  <= PORT_PIPE;
            we_q      <= 1'b0;
            inrange_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            winner_q  <= winner_d;
            we_q      <= we_d;
            inrange_q <= inrange_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Response routing. Read data cannot be registered at grant time because
    // the memory only presents it in the RESP cycle, so the captured winner
    // info selects it there. Reset suppresses a response that is in flight.
    always_comb begin
        resp_live = rvalid_q && !reset;
        resp_data = (we_q || !inrange_q) ? 64'd0 : mem_rdata;
        p0_rvalid = resp_live && (winner_q == PORT_PIPE);
        p1_rvalid = resp_live && (winner_q == PORT_LOAD);
        p0_rdata  = p0_rvalid ? resp_data : 64'd0;
        p1_rdata  = p1_rvalid ? resp_data : 64'd0;
        p0_err    = p0_rvalid && !inrange_q;
        p1_err    = p1_rvalid && !inrange_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: directed scenarios for the basic
// read/write paths, priority, starvation and address errors, followed by a
// randomized run checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [63:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    logic [63:0] tbMem [0:4095];
    logic        bdWe;
    logic [11:0] bdAddr;
    logic [63:0] bdData;

    int checks = 0;
    int errors = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural synchronous-read memory, plus a backdoor write port used to
    // preload contents while the arbiter sits idle.
    always @(posedge clk) begin
        if (bdWe) begin
            tbMem[bdAddr] <= bdData;
        end else if (mem_en) begin
            if (mem_we) begin
                tbMem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= tbMem[mem_addr];
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one port's request fields.
    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // Preload one memory word through the backdoor while no port requests.
    task automatic preload(input logic [11:0] addr, input logic [63:0] data);
        bdWe = 1'b1; bdAddr = addr; bdData = data;
        step();
        bdWe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 64'd5, 64'd0);
        applyStimulus(1, 1'b1, 1'b1, 64'd7, 64'd9);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", {p0_gnt, p1_gnt});
        end
        checks++;
        if ({mem_en, mem_we} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_mem: got %b expected 00", {mem_en, mem_we});
        end
        checks++;
        if ({p0_rvalid, p0_err, p1_rvalid, p1_err, p0_rdata, p1_rdata} !== '0) begin
            errors++; $display("[TB] FAIL reset_resp: got %b%b%b%b %h %h expected all zero",
                               p0_rvalid, p0_err, p1_rvalid, p1_err, p0_rdata, p1_rdata);
        end
        step();
        step();
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        reset = 1'b0;
        preload(12'd5, 64'hDEAD);
        preload(12'd0, 64'h0123_4567_89AB_CDEF);
        preload(12'd4095, 64'hCAFE_F00D);
    endtask

    task automatic test_p0_read();
        applyStimulus(0, 1'b1, 1'b0, 64'd5, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 12'd5}) begin
            errors++; $display("[TB] FAIL p0_read_grant: got %b%b%b%b addr %0d expected 1010 addr 5",
                               p0_gnt, p1_gnt, mem_en, mem_we, mem_addr);
        end
        step();
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p0_err, p0_rdata, p1_rvalid} !== {2'b10, 64'hDEAD, 1'b0}) begin
            errors++; $display("[TB] FAIL p0_read_resp: got v%b e%b %h p1v%b expected v1 e0 dead p1v0",
                               p0_rvalid, p0_err, p0_rdata, p1_rvalid);
        end
        step();
    endtask

    task automatic test_p1_write_read();
        applyStimulus(1, 1'b1, 1'b1, 64'd100, 64'h1234);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0111, 12'd100, 64'h1234}) begin
            errors++; $display("[TB] FAIL p1_write_grant: got %b%b%b%b addr %0d data %h expected 0111 addr 100 data 1234",
                               p0_gnt, p1_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        step();
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if ({p1_rvalid, p1_err, p1_rdata} !== {2'b10, 64'd0}) begin
            errors++; $display("[TB] FAIL p1_write_resp: got v%b e%b %h expected v1 e0 0", p1_rvalid, p1_err, p1_rdata);
        end
        step();
        checks++;
        if (tbMem[100] !== 64'h1234) begin
            errors++; $display("[TB] FAIL p1_write_mem: got %h expected 1234", tbMem[100]);
        end
        applyStimulus(1, 1'b1, 1'b0, 64'd100, 64'd0);
        @(negedge clk);
        checks++;
        if ({p1_gnt, mem_en, mem_we} !== 3'b110) begin
            errors++; $display("[TB] FAIL p1_read_grant: got %b%b%b expected 110", p1_gnt, mem_en, mem_we);
        end
        step();
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if ({p1_rvalid, p1_err, p1_rdata} !== {2'b10, 64'h1234}) begin
            errors++; $display("[TB] FAIL p1_read_resp: got v%b e%b %h expected v1 e0 1234", p1_rvalid, p1_err, p1_rdata);
        end
        step();
    endtask

    task automatic test_simultaneous();
        applyStimulus(0, 1'b1, 1'b0, 64'd5, 64'd0);
        applyStimulus(1, 1'b1, 1'b0, 64'd100, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            errors++; $display("[TB] FAIL simul_first: got %b expected 10", {p0_gnt, p1_gnt});
        end
        step();
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata} !== {4'b0010, 64'hDEAD}) begin
            errors++; $display("[TB] FAIL simul_resp_cycle: got %b%b%b%b %h expected 0010 dead",
                               p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, mem_en, mem_addr} !== {3'b011, 12'd100}) begin
            errors++; $display("[TB] FAIL simul_second: got %b%b%b addr %0d expected 011 addr 100",
                               p0_gnt, p1_gnt, mem_en, mem_addr);
        end
        step();
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p1_rvalid, p1_rdata} !== {2'b01, 64'h1234}) begin
            errors++; $display("[TB] FAIL simul_p1_resp: got %b%b %h expected 01 1234", p0_rvalid, p1_rvalid, p1_rdata);
        end
        step();
    endtask

    task automatic test_starvation();
        int p0Cnt = 0;
        int p1Cnt = 0;
        int firstP1 = -1;
        applyStimulus(0, 1'b1, 1'b0, 64'd5, 64'd0);
        applyStimulus(1, 1'b1, 1'b0, 64'd100, 64'd0);
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            checks++;
            if (p0_gnt && p1_gnt) begin
                errors++; $display("[TB] FAIL starve_onehot: got 11 expected at most one grant (cycle %0d)", c);
            end
            if (p0_gnt) p0Cnt++;
            if (p1_gnt) begin
                p1Cnt++;
                if (firstP1 < 0) firstP1 = c;
            end
            step();
        end
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        checks++;
        if (firstP1 != 16) begin
            errors++; $display("[TB] FAIL starve_first_p1: got cycle %0d expected cycle 16", firstP1);
        end
        checks++;
        if ({p0Cnt, p1Cnt} != {32'd16, 32'd2}) begin
            errors++; $display("[TB] FAIL starve_ratio: got p0 %0d p1 %0d expected p0 16 p1 2", p0Cnt, p1Cnt);
        end
        step();
    endtask

    task automatic test_addr_error();
        applyStimulus(0, 1'b1, 1'b0, 64'd4096, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_gnt, mem_en} !== 2'b10) begin
            errors++; $display("[TB] FAIL adrerr_read_grant: got %b%b expected 10", p0_gnt, mem_en);
        end
        step();
        applyStimulus(0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBAD);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p0_rvalid, p0_err, p0_rdata} !== {3'b011, 64'd0}) begin
            errors++; $display("[TB] FAIL adrerr_read_resp: got g%b v%b e%b %h expected g0 v1 e1 0",
                               p0_gnt, p0_rvalid, p0_err, p0_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if ({p0_gnt, mem_en, mem_we} !== 3'b100) begin
            errors++; $display("[TB] FAIL adrerr_write_grant: got %b%b%b expected 100", p0_gnt, mem_en, mem_we);
        end
        step();
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p0_err, p0_rdata} !== {2'b11, 64'd0}) begin
            errors++; $display("[TB] FAIL adrerr_write_resp: got v%b e%b %h expected v1 e1 0", p0_rvalid, p0_err, p0_rdata);
        end
        checks++;
        if ({tbMem[4095], tbMem[0]} !== {64'hCAFE_F00D, 64'h0123_4567_89AB_CDEF}) begin
            errors++; $display("[TB] FAIL adrerr_mem_intact: got %h %h expected cafef00d 0123456789abcdef",
                               tbMem[4095], tbMem[0]);
        end
        step();
    endtask

    task automatic test_reset_in_resp();
        applyStimulus(0, 1'b1, 1'b0, 64'd5, 64'd0);
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1) begin
            errors++; $display("[TB] FAIL rstresp_grant: got %b expected 1", p0_gnt);
        end
        step();
        reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p0_err, p1_rvalid, p1_err, mem_en, mem_we, p0_rdata} !== '0) begin
            errors++; $display("[TB] FAIL rstresp_quiet: got %b%b%b%b%b%b%b%b %h expected all zero",
                               p0_gnt, p1_gnt, p0_rvalid, p0_err, p1_rvalid, p1_err, mem_en, mem_we, p0_rdata);
        end
        step();
        reset = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 64'd100, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_gnt, mem_en, mem_addr} !== {2'b11, 12'd100}) begin
            errors++; $display("[TB] FAIL rstresp_regrant: got %b%b addr %0d expected 11 addr 100", p0_gnt, mem_en, mem_addr);
        end
        step();
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p0_err, p0_rdata} !== {2'b10, 64'h1234}) begin
            errors++; $display("[TB] FAIL rstresp_reread: got v%b e%b %h expected v1 e0 1234", p0_rvalid, p0_err, p0_rdata);
        end
        step();
    endtask

    // Randomized traffic against a transaction-level model: each port holds a
    // pending request until granted, the arbiter serves one transaction per
    // two cycles, and port 1 jumps the queue once it has been refused in eight
    // consecutive arbitration opportunities.
    task automatic test_random();
        logic [63:0] refMem [0:15];
        logic        pend [2];
        logic        pwe [2];
        logic [63:0] paddr [2];
        logic [63:0] pwdata [2];
        logic        busy = 1'b0;
        int          p1Wait = 0;
        logic        rsValid = 1'b0;
        int          rsPort = 0;
        logic        rsErr = 1'b0;
        logic [63:0] rsData = '0;
        logic        doReset, expG0, expG1, expOk, expEn, expRv0, expRv1;
        int          win, r;

        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            refMem[i] = {$urandom, $urandom};
            preload(12'(i), refMem[i]);
        end

        for (int c = 0; c < 600; c++) begin
            doReset = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) != 0) begin
                    pend[p] = 1'b1;
                    pwe[p] = 1'($urandom_range(0, 1));
                    r = $urandom_range(0, 9);
                    if (r == 0) paddr[p] = 64'(4096 + $urandom_range(0, 3));
                    else if (r == 1) paddr[p] = {1'b1, 31'($urandom), $urandom};
                    else paddr[p] = 64'($urandom_range(0, 15));
                    pwdata[p] = {$urandom, $urandom};
                end
            end
            reset = doReset;
            applyStimulus(0, pend[0], pwe[0], paddr[0], pwdata[0]);
            applyStimulus(1, pend[1], pwe[1], paddr[1], pwdata[1]);

            expG0 = 1'b0;
            expG1 = 1'b0;
            if (!doReset && !busy) begin
                if (pend[1] && p1Wait >= 8) expG1 = 1'b1;
                else if (pend[0]) expG0 = 1'b1;
                else if (pend[1]) expG1 = 1'b1;
            end
            win = expG1 ? 1 : 0;
            expOk = (paddr[win] < 64'd4096);
            expEn = (expG0 || expG1) && expOk;
            expRv0 = rsValid && !doReset && (rsPort == 0);
            expRv1 = rsValid && !doReset && (rsPort == 1);

            @(negedge clk);
            checks++;
            if ({p0_gnt, p1_gnt} !== {expG0, expG1}) begin
                errors++; $display("[TB] FAIL rand_gnt c%0d: got %b%b expected %b%b", c, p0_gnt, p1_gnt, expG0, expG1);
            end
            checks++;
            if (mem_en !== expEn) begin
                errors++; $display("[TB] FAIL rand_mem_en c%0d: got %b expected %b", c, mem_en, expEn);
            end
            if (expEn) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {pwe[win], paddr[win][11:0], pwdata[win]}) begin
                    errors++; $display("[TB] FAIL rand_mem_req c%0d: got we%b %h %h expected we%b %h %h", c,
                                       mem_we, mem_addr, mem_wdata, pwe[win], paddr[win][11:0], pwdata[win]);
                end
            end
            checks++;
            if ({p0_rvalid, p0_err, p0_rdata} !== {expRv0, expRv0 && rsErr, expRv0 ? rsData : 64'd0}) begin
                errors++; $display("[TB] FAIL rand_p0_resp c%0d: got v%b e%b %h expected v%b e%b %h", c,
                                   p0_rvalid, p0_err, p0_rdata, expRv0, expRv0 && rsErr, expRv0 ? rsData : 64'd0);
            end
            checks++;
            if ({p1_rvalid, p1_err, p1_rdata} !== {expRv1, expRv1 && rsErr, expRv1 ? rsData : 64'd0}) begin
                errors++; $display("[TB] FAIL rand_p1_resp c%0d: got v%b e%b %h expected v%b e%b %h", c,
                                   p1_rvalid, p1_err, p1_rdata, expRv1, expRv1 && rsErr, expRv1 ? rsData : 64'd0);
            end

            if (doReset) begin
                busy = 1'b0;
                p1Wait = 0;
                rsValid = 1'b0;
            end else begin
                rsValid = expG0 || expG1;
                rsPort = win;
                rsErr = !expOk;
                rsData = ((expG0 || expG1) && !pwe[win] && expOk) ? refMem[paddr[win][3:0]] : 64'd0;
                if ((expG0 || expG1) && pwe[win] && expOk) refMem[paddr[win][3:0]] = pwdata[win];
                if (!busy) begin
                    if (expG1 || !pend[1]) p1Wait = 0;
                    else p1Wait++;
                end
                busy = expG0 || expG1;
                if (expG0) pend[0] = 1'b0;
                if (expG1) pend[1] = 1'b0;
            end
            step();
        end
        reset = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        step();
        step();
    endtask

    initial begin
        reset = 1'b1;
        bdWe = 1'b0;
        bdAddr = '0;
        bdData = '0;
        applyStimulus(0, 1'b0, 1'b0, 64'd0, 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 64'd0, 64'd0);
        test_reset();
        test_p0_read();
        test_p1_write_read();
        test_simultaneous();
        test_starvation();
        test_addr_error();
        test_reset_in_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 4096 x 64 data memory between two requesters.
  - Port 0: pipeline memory stage (priority).
  - Port 1: loader/debug port that preloads or inspects data memory.
- Fixed priority to port 0, with a starvation guard that forces a port-1 win after a bounded wait.
- Sequences each access through a small FSM, checks addresses, and returns read data or an address-error response one cycle after grant.

Parameters:
- DEPTH, 4096, number of 64-bit words in data memory.
- ADDR_W, 12, memory address width; log2(DEPTH).
- STARVE_LIMIT, 8, consecutive denied cycles of p1_req after which port 1 wins the next arbitration.
- STARVE_W, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 access request; held until granted.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  64  port 0 word address.
- p0_wdata  in  64  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle (combinational); low means the stage must stall.
- p0_rvalid  out  1  port 0 response valid (read data or error), one cycle after grant.
- p0_rdata  out  64  port 0 read data; 0 on error or write.
- p0_err  out  1  port 0 address error, qualified by p0_rvalid.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same definitions for port 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, valid the cycle after a read strobe (synchronous read).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - FSM in IDLE; starvation counter 0.
  - All p*_rvalid, p*_err and p*_rdata are 0.
  - mem_en and mem_we are 0.
  - No grant during the reset cycle.
- FSM states:
  - IDLE: arbitration allowed.
  - RESP: one response cycle after a grant.
  - Transitions:
    - IDLE -> RESP on any grant.
    - RESP -> IDLE unconditionally.
  - No grant is issued in RESP, so each port can be granted at most every 2 cycles.
- Arbitration in IDLE (combinational):
  - If starve_cnt == STARVE_LIMIT and p1_req, grant port 1.
  - Else if p0_req, grant port 0.
  - Else if p1_req, grant port 1.
  - At most one gnt is high per cycle.
- Address check on the granted port:
  - in_range = (addr < DEPTH); the upper 52 bits must be zero.
  - In range: mem_en = 1, mem_we = winner's we, mem_addr = addr[ADDR_W-1:0], mem_wdata = winner's wdata, all in the grant cycle.
  - Out of range: mem_en = 0; no memory side effect.
- Response in RESP (registered, winner port only):
  - rvalid = 1 for both reads and writes.
  - Read in range: rdata = mem_rdata, err = 0.
  - Write in range: rdata = 0, err = 0.
  - Out of range: rdata = 0, err = 1.
  - The losing port's rvalid stays 0.
- Registered winner info: winner id, we and in_range are captured at grant.
- Starvation counter:
  - Increments each IDLE cycle with p1_req = 1 and p1_gnt = 0, saturating at STARVE_LIMIT.
  - Clears on p1_gnt or when p1_req = 0.
  - Holds during RESP.
- Simultaneous requests: p0 wins unless starved-override applies; a denied requester keeps req high.
- A request asserted during RESP waits; it is arbitrated in the following IDLE cycle.
- Reset mid-operation (in RESP): the FSM goes to IDLE and no rvalid is produced for the in-flight access. A write already strobed stays committed.
- Address wrap: none. An address equal to DEPTH or any larger value is an error; there is no modulo.

Decomposition:
- Shared package dmem_pkg:
  - DEPTH, ADDR_W and the 64-bit word width.
  - FSM state encoding (IDLE = 0, RESP = 1).
  - Port-id constants (PORT_PIPE = 0, PORT_LOAD = 1).
  - The ADR status code 4'b0010, which the memory stage uses when mapping p0_err to m_stat.
- One sub-module: dmem_prio_arb, the combinational two-way priority picker with starve override. Inputs p0_req, p1_req, starve_hit, idle; outputs are the two one-hot grants. FSM, counter and response registers stay in the top module.

Test Plan:
- p0 read only: preload mem[5] = 0xDEAD, p0_req/addr 5/we 0 in IDLE -> p0_gnt same cycle, mem_en = 1, mem_addr = 5; next cycle p0_rvalid = 1, p0_rdata = 0xDEAD, p0_err = 0.
- Write then read-back on port 1: write 0x1234 to addr 100 -> p1_gnt, mem_we = 1, response cycle rdata = 0; 2 cycles later read addr 100 -> p1_rdata = 0x1234.
- Simultaneous requests: both req, same cycle -> p0_gnt = 1, p1_gnt = 0; p1 granted in the next IDLE cycle (cycle +2) if p0_req drops.
- Starvation: p0_req and p1_req held high continuously -> p1_gnt asserts by the time starve_cnt reaches 8 denied IDLE cycles, after which the counter clears. Check p0/p1 grant count ratio and that no two gnts are high together.
- Address error: p0 read addr 4096, then write addr 0xFFFF_FFFF_FFFF_FFFF -> mem_en = 0 both times; responses p0_rvalid = 1, p0_err = 1, p0_rdata = 0; memory contents unchanged.
- Reset in RESP: grant a read, assert reset on the next cycle -> no p0_rvalid, all outputs 0, FSM IDLE; a new request after reset is served normally.
